// File: rtl/adc_sample_serializer.sv
// adc_sample_serializer: buffers decimated CIC samples in a small FIFO and
// shifts them out MSB-first on a framed serial link (sclk/sdata/frame).
// Ports:
//   clk, rst          - system clock; asynchronous active-high reset
//   data_in, new_data - sample from the filter and its one-cycle strobe
//   enable            - permits starting new serial words
//   ovf_clr           - clears the sticky overflow flag
//   sclk_out          - serial clock, receiver samples on its rising edge
//   sdata_out         - serial data, MSB first
//   frame_out         - high for exactly the DATA_W bits of one word
//   fifo_count        - entries held, 0..FIFO_DEPTH
//   overflow          - sticky: a sample was dropped because the FIFO was full
module adc_sample_serializer #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               data_in,
    input  logic                            new_data,
    input  logic                            enable,
    input  logic                            ovf_clr,
    output logic                            sclk_out,
    output logic                            sdata_out,
    output logic                            frame_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(DATA_W);

    localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DW-1:0]     div_cnt, div_n;
    logic [BW-1:0]     bit_cnt, bit_n;
    logic              full, pop, push;

    assign full = (count == CNT_FULL);
    // The head is consumed on the LOAD->SHIFT edge, which frees a slot for a
    // simultaneous push even when the FIFO is full.
    assign pop  = (state == LOAD);
    assign push = new_data && (!full || pop);

    assign fifo_count = count;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        unique case (state)
            IDLE: begin
                if (enable && count != '0) state_n = LOAD;
            end
            LOAD: begin
                state_n = SHIFT;
                shreg_n = mem[rd_ptr];
                div_n   = '0;
                bit_n   = '0;
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = GAP;
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        shreg_n = {shreg[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (div_cnt == DIV_LAST) begin
                    state_n = IDLE;
                    div_n   = '0;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            sclk_out  <= 1'b0;
            sdata_out <= 1'b0;
            frame_out <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            div_cnt   <= div_n;
            bit_cnt   <= bit_n;
            // Outputs are registered from next-state values so the pins
            // come straight from flops yet line up with the FSM state.
            frame_out <= (state_n == SHIFT);
            sclk_out  <= (state_n == SHIFT) && (div_n >= DIV_HALF);
            sdata_out <= (state_n == SHIFT) && shreg_n[DATA_W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set takes priority over a same-cycle clear.
            if (new_data && full && !pop) overflow <= 1'b1;
            else if (ovf_clr)             overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_adc_sample_serializer.sv
// Testbench for adc_sample_serializer: scoreboard queue filled by stimulus,
// serial receiver monitor pops and compares each completed frame.
module tb_adc_sample_serializer;

    localparam int DW    = 12;
    localparam int DEPTH = 8;
    localparam int CD    = 2;
    localparam int FLEN  = DW * 2 * CD;
    // Word period (DW+1)*2*CD+2 minus frame length gives the low time.
    localparam int LOWT  = (DW + 1) * 2 * CD + 2 - FLEN;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          new_data;
    logic          enable;
    logic          ovf_clr;
    logic          sclk_out;
    logic          sdata_out;
    logic          frame_out;
    logic [3:0]    fifo_count;
    logic          overflow;

    adc_sample_serializer #(
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH),
        .CLK_DIV   (CD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .new_data  (new_data),
        .enable    (enable),
        .ovf_clr   (ovf_clr),
        .sclk_out  (sclk_out),
        .sdata_out (sdata_out),
        .frame_out (frame_out),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q[$];

    // Receiver state
    bit            in_frame  = 0;
    bit            prev_sclk = 0;
    logic [DW-1:0] word;
    int            nbits     = 0;
    int            flen      = 0;
    int            frames    = 0;
    int            rise_cyc  = 0;
    int            fall_cyc  = 0;
    int            last_gap  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame  = 0;
                prev_sclk = 0;
                nbits     = 0;
                flen      = 0;
            end else begin
                if (frame_out && !in_frame) begin
                    in_frame = 1;
                    frames++;
                    rise_cyc = cyc;
                    last_gap = cyc - fall_cyc;
                    flen     = 0;
                    nbits    = 0;
                    word     = '0;
                end
                if (in_frame) begin
                    if (frame_out) begin
                        flen++;
                        if (sclk_out && !prev_sclk) begin
                            word = {word[DW-2:0], sdata_out};
                            nbits++;
                        end
                    end else begin
                        in_frame = 0;
                        fall_cyc = cyc;
                        if (exp_q.size() == 0) begin
                            check("unexpected_word", {20'd0, word}, 32'hFFFF_FFFF);
                        end else begin
                            check("word", {20'd0, word}, {20'd0, exp_q.pop_front()});
                        end
                        check("bits", nbits, DW);
                        check("frame_len", flen, FLEN);
                    end
                end
                prev_sclk = sclk_out;
            end
        end
    end

    // Caller sits just after a negedge; strobe lands on the next posedge.
    task automatic push_sample(input logic [DW-1:0] d, input bit keep);
        data_in  = d;
        new_data = 1'b1;
        if (keep) exp_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !in_frame && fifo_count == 0) break;
            @(negedge clk);
        end
        check("drain_in_time", (i < budget), 1);
        repeat (2 * CD + 2) @(negedge clk);
    endtask

    int t0;
    int f0;
    int k;

    initial begin
        rst      = 1'b1;
        data_in  = '0;
        new_data = 1'b0;
        enable   = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {sclk_out, sdata_out, frame_out, overflow}, 0);
        check("rst_count", fifo_count, 0);
        rst    = 1'b0;
        enable = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_frames", frames, 0);
        check("idle_frame_out", frame_out, 0);

        // Single word and latency
        push_sample(12'hA5C, 1);
        t0       = cyc;
        new_data = 1'b0;
        wait_drain(200);
        check("latency_rise", rise_cyc, t0 + 2);
        check("single_frames", frames, 1);

        // Back-to-back, held while enable is low
        enable = 1'b0;
        push_sample(12'h001, 1);
        push_sample(12'hFFF, 1);
        push_sample(12'h800, 1);
        new_data = 1'b0;
        check("b2b_peak", fifo_count, 3);
        enable = 1'b1;
        wait_drain(400);
        check("b2b_gap", last_gap, LOWT);
        check("b2b_count", fifo_count, 0);

        // Overflow: 9th sample lost
        enable = 1'b0;
        for (k = 0; k < 9; k++) push_sample(DW'(12'h100 + k), k < 8);
        new_data = 1'b0;
        check("ovf_count", fifo_count, 8);
        check("ovf_set", overflow, 1);
        enable = 1'b1;
        wait_drain(8 * 60 + 50);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO with a strobe on the LOAD->SHIFT edge
        enable = 1'b0;
        for (k = 0; k < 8; k++) push_sample(DW'(12'h300 + k), 1);
        new_data = 1'b0;
        check("full_count", fifo_count, 8);
        enable = 1'b1;
        @(negedge clk);
        push_sample(12'hABC, 1);
        new_data = 1'b0;
        check("full_simul_count", fifo_count, 8);
        check("full_simul_ovf", overflow, 0);
        wait_drain(9 * 60 + 50);

        // Mid-word asynchronous reset
        push_sample(12'h5A5, 1);
        new_data = 1'b0;
        for (k = 0; k < 200; k++) begin
            if (nbits >= 6) break;
            @(negedge clk);
        end
        check("reach_bit5", (k < 200), 1);
        #1 rst = 1'b1;
        #1;
        check("async_outputs", {sclk_out, sdata_out, frame_out, overflow}, 0);
        check("async_count", fifo_count, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        f0  = frames;
        repeat (60) @(negedge clk);
        check("post_rst_frames", frames, f0);
        check("post_rst_count", fifo_count, 0);
        check("post_rst_frame_out", frame_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
